// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter and its helpers.
//   state_e : arbiter FSM states
//   owner_e : which CPU port owns the transaction in flight
//   ERR_DATA_DEFAULT : read data returned to a port whose transaction timed out
package rv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/rv_mem_timeout.sv
// Loadable cycle counter with clear/enable and an expire flag.
// expire is high while enabled and the count sits at TIMEOUT_CYC-1.
// TIMEOUT_CYC = 0 disables the counter entirely (expire never asserts).
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   clear            : force count to zero (highest priority)
//   load, load_val   : load an arbitrary start count
//   enable           : count one step per cycle
//   expire           : terminal count reached while enabled
module rv_mem_timeout #(
  parameter int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             expire
);

  localparam bit               ENABLED = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ENABLED ? TIMEOUT_CYC - 1 : 0);

  logic [CNT_W-1:0] count;

  // Holds at LAST rather than wrapping so a stuck owner keeps seeing expire.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && ENABLED && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one single-ported memory between the CPU fetch port and data port.
// IDLE arbitrates and latches the winning request, REQ presents it to memory
// until accepted, RESP waits for read data. Fetch is forced after
// STARVE_LIMIT consecutive data grants; a transaction stuck for TIMEOUT_CYC
// cycles is aborted with ERR_DATA and a bus_err pulse.
// Ports:
//   clk, reset                          : clock, synchronous active-low reset
//   if_req/if_addr -> if_rdata/if_done/if_stall : fetch port
//   d_rd/d_wr/d_addr/d_wdata/d_wstrb -> d_rdata/d_done/d_stall : data port
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb : latched memory request
//   mem_ready/mem_rvalid/mem_rdata      : memory handshake and read data
//   bus_err                             : one-cycle pulse on timeout abort
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 64,
  parameter logic [31:0] ERR_DATA     = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int unsigned         STREAK_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  state_e              state;
  owner_e              owner;
  logic [STREAK_W-1:0] streak;
  logic [31:0]         if_rdata_q;
  logic [31:0]         d_rdata_q;

  logic d_pend;
  logic grant_data;
  logic wr_cmpl;
  logic rd_cmpl;
  logic cmpl;
  logic tmo_expire;
  logic abort;
  logic finish;

  rv_mem_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .load     (1'b0),
    .load_val ('0),
    .enable   (state != IDLE),
    .expire   (tmo_expire)
  );

  assign d_pend     = d_rd | d_wr;
  // Data wins unless fetch is waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  assign grant_data = d_pend && (!if_req || (streak < STREAK_MAX));

  // mem_rvalid only counts in RESP, so a response overlapping the
  // REQ->RESP transition or arriving in IDLE is ignored.
  assign wr_cmpl = (state == REQ) && mem_ready && mem_we;
  assign rd_cmpl = (state == RESP) && mem_rvalid;
  assign cmpl    = wr_cmpl || rd_cmpl;
  // A completion on the expiry cycle wins over the abort.
  assign abort   = tmo_expire && !cmpl;
  assign finish  = reset && (cmpl || abort);

  assign if_done  = finish && (owner == FETCH);
  assign d_done   = finish && (owner == DATA);
  assign bus_err  = reset && abort;
  assign if_stall = if_req & ~if_done;
  assign d_stall  = d_pend & ~d_done;

  assign if_rdata = !if_done ? if_rdata_q : (abort ? ERR_DATA : mem_rdata);
  assign d_rdata  = (d_done && abort)   ? ERR_DATA  :
                    (d_done && rd_cmpl) ? mem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= NONE;
      streak     <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_done) if_rdata_q <= if_rdata;
      if (d_done)  d_rdata_q  <= d_rdata;

      case (state)
        IDLE: begin
          if (grant_data) begin
            owner     <= DATA;
            mem_valid <= 1'b1;
            mem_we    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wr ? d_wstrb : 4'b0000;
            state     <= REQ;
            if (!if_req)                streak <= '0;
            else if (streak != STREAK_MAX) streak <= streak + 1'b1;
          end else if (if_req) begin
            owner     <= FETCH;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= 4'b0000;
            state     <= REQ;
            streak    <= '0;
          end
        end

        REQ: begin
          if (abort) begin
            mem_valid <= 1'b0;
            owner     <= NONE;
            state     <= IDLE;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_we) begin
              owner <= NONE;
              state <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end

        RESP: begin
          if (rd_cmpl || abort) begin
            owner <= NONE;
            state <= IDLE;
          end
        end

        default: begin
          owner     <= NONE;
          mem_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed bench for rv_mem_arbiter: a per-cycle vector table against a
// zero-wait memory, then hand-written sequences for wait states, timeout,
// completion on the expiry cycle and reset in the middle of a read.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  always #5 clk = ~clk;

  rv_mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT_CYC  (8),
    .ERR_DATA     (32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_done    (if_done),
    .if_stall   (if_stall),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_wstrb    (d_wstrb),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .d_stall    (d_stall),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bus_err    (bus_err)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req     = 1'b0;
    if_addr    = 32'h0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    d_wstrb    = 4'h0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  // Zero-wait fetch from IDLE: mem_valid in cycle 1, if_done in cycle 2.
  task automatic fetch_zw(input logic [31:0] a, input logic [31:0] dat, input string tag);
    tick();
    idle_inputs();
    if_req = 1'b1; if_addr = a; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = dat;
    @(negedge clk);
    chk1({tag, " c0 if_done"}, if_done, 1'b0);
    chk1({tag, " c0 if_stall"}, if_stall, 1'b1);
    tick();
    @(negedge clk);
    chk1({tag, " c1 mem_valid"}, mem_valid, 1'b1);
    chk32({tag, " c1 mem_addr"}, mem_addr, a);
    tick();
    @(negedge clk);
    chk1({tag, " c2 if_done"}, if_done, 1'b1);
    chk32({tag, " c2 if_rdata"}, if_rdata, dat);
    chk1({tag, " c2 bus_err"}, bus_err, 1'b0);
    tick();
    idle_inputs();
  endtask

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] mem_rdata;
    logic        e_valid;
    logic        e_we;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic        e_if_done;
    logic        e_d_done;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  localparam int          NV = 30;
  localparam logic [31:0] J  = 32'hBAD0_0000;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] P1 = 32'h0010_0313;
  localparam logic [31:0] A1 = 32'hAAAA_0001;

  vec_t tv [NV];

  initial begin
    begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench did not finish");
    end
  end

  initial begin
    // Fetch zero-wait, then simultaneous fetch + store, then fetch starvation.
    tv[0]  = '{1'b1, 32'h10, 1'b0, 1'b0, Z, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,      1'b0, 1'b0, Z, Z};
    tv[1]  = '{1'b1, 32'h10, 1'b0, 1'b0, Z, Z, 4'h0, J,            1'b1, 1'b0, 32'h10, 4'h0, 1'b0, 1'b0, Z, Z};
    tv[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, Z, Z, 4'h0, P1,           1'b0, 1'b0, Z, 4'h0,      1'b1, 1'b0, P1, Z};
    tv[3]  = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h100, 32'h5, 4'h1, J,  1'b0, 1'b0, Z, 4'h0,      1'b0, 1'b0, P1, Z};
    tv[4]  = '{1'b1, 32'h20, 1'b0, 1'b1, 32'h100, 32'h5, 4'h1, J,  1'b1, 1'b1, 32'h100, 4'h1, 1'b0, 1'b1, P1, Z};
    tv[5]  = '{1'b1, 32'h20, 1'b0, 1'b0, Z, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,      1'b0, 1'b0, P1, Z};
    tv[6]  = '{1'b1, 32'h20, 1'b0, 1'b0, Z, Z, 4'h0, J,            1'b1, 1'b0, 32'h20, 4'h0, 1'b0, 1'b0, P1, Z};
    tv[7]  = '{1'b1, 32'h20, 1'b0, 1'b0, Z, Z, 4'h0, A1,           1'b0, 1'b0, Z, 4'h0,      1'b1, 1'b0, A1, Z};
    tv[8]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, A1, Z};
    tv[9]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b0, A1, Z};
    tv[10] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h11111111, 1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b1, A1, 32'h11111111};
    tv[11] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, A1, 32'h11111111};
    tv[12] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b0, A1, 32'h11111111};
    tv[13] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h22222222, 1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b1, A1, 32'h22222222};
    tv[14] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, A1, 32'h22222222};
    tv[15] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b0, A1, 32'h22222222};
    tv[16] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h33333333, 1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b1, A1, 32'h33333333};
    tv[17] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, A1, 32'h33333333};
    tv[18] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b0, A1, 32'h33333333};
    tv[19] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h44444444, 1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b1, A1, 32'h44444444};
    tv[20] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, A1, 32'h44444444};
    tv[21] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h40, 4'h0,  1'b0, 1'b0, A1, 32'h44444444};
    tv[22] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h55555555, 1'b0, 1'b0, Z, 4'h0,       1'b1, 1'b0, 32'h55555555, 32'h44444444};
    tv[23] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, 32'h55555555, 32'h44444444};
    tv[24] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, J,            1'b1, 1'b0, 32'h200, 4'h0, 1'b0, 1'b0, 32'h55555555, 32'h44444444};
    tv[25] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h200, Z, 4'h0, 32'h66666666, 1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b1, 32'h55555555, 32'h66666666};
    tv[26] = '{1'b1, 32'h40, 1'b0, 1'b0, Z, Z, 4'h0, J,                  1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, 32'h55555555, 32'h66666666};
    tv[27] = '{1'b1, 32'h40, 1'b0, 1'b0, Z, Z, 4'h0, J,                  1'b1, 1'b0, 32'h40, 4'h0,  1'b0, 1'b0, 32'h55555555, 32'h66666666};
    tv[28] = '{1'b1, 32'h40, 1'b0, 1'b0, Z, Z, 4'h0, 32'h77777777,       1'b0, 1'b0, Z, 4'h0,       1'b1, 1'b0, 32'h77777777, 32'h66666666};
    tv[29] = '{1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, J,                       1'b0, 1'b0, Z, 4'h0,       1'b0, 1'b0, 32'h77777777, 32'h66666666};

    // Reset state
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst mem_valid", mem_valid, 1'b0);
    chk1("rst mem_we", mem_we, 1'b0);
    chk32("rst mem_addr", mem_addr, 32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk32("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk1("rst bus_err", bus_err, 1'b0);
    chk1("rst if_done", if_done, 1'b0);
    chk1("rst d_done", d_done, 1'b0);
    chk32("rst if_rdata", if_rdata, 32'h0);
    chk32("rst d_rdata", d_rdata, 32'h0);
    tick();
    reset = 1'b1;

    // Table: zero-wait memory, one row per clock cycle
    for (int i = 0; i < NV; i++) begin
      tick();
      if_req     = tv[i].if_req;
      if_addr    = tv[i].if_addr;
      d_rd       = tv[i].d_rd;
      d_wr       = tv[i].d_wr;
      d_addr     = tv[i].d_addr;
      d_wdata    = tv[i].d_wdata;
      d_wstrb    = tv[i].d_wstrb;
      mem_rdata  = tv[i].mem_rdata;
      mem_ready  = 1'b1;
      mem_rvalid = 1'b1;
      @(negedge clk);
      chk1($sformatf("r%0d mem_valid", i), mem_valid, tv[i].e_valid);
      chk1($sformatf("r%0d if_done", i), if_done, tv[i].e_if_done);
      chk1($sformatf("r%0d d_done", i), d_done, tv[i].e_d_done);
      chk1($sformatf("r%0d if_stall", i), if_stall, tv[i].if_req & ~tv[i].e_if_done);
      chk1($sformatf("r%0d d_stall", i), d_stall, (tv[i].d_rd | tv[i].d_wr) & ~tv[i].e_d_done);
      chk32($sformatf("r%0d if_rdata", i), if_rdata, tv[i].e_if_rdata);
      chk32($sformatf("r%0d d_rdata", i), d_rdata, tv[i].e_d_rdata);
      chk1($sformatf("r%0d bus_err", i), bus_err, 1'b0);
      if (tv[i].e_valid) begin
        chk1($sformatf("r%0d mem_we", i), mem_we, tv[i].e_we);
        chk32($sformatf("r%0d mem_addr", i), mem_addr, tv[i].e_addr);
        chk32($sformatf("r%0d mem_wstrb", i), {28'h0, mem_wstrb}, {28'h0, tv[i].e_wstrb});
      end
    end

    // A: ready after 3 REQ cycles, rvalid 3 cycles into RESP
    tick();
    idle_inputs();
    d_rd = 1'b1; d_addr = 32'h300;
    @(negedge clk);
    chk1("A c0 mem_valid", mem_valid, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      mem_ready = (c == 3);
      @(negedge clk);
      chk1($sformatf("A c%0d mem_valid", c), mem_valid, 1'b1);
      chk32($sformatf("A c%0d mem_addr", c), mem_addr, 32'h300);
      chk1($sformatf("A c%0d d_done", c), d_done, 1'b0);
      chk1($sformatf("A c%0d d_stall", c), d_stall, 1'b1);
    end
    for (int c = 4; c <= 5; c++) begin
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      chk1($sformatf("A c%0d mem_valid", c), mem_valid, 1'b0);
      chk1($sformatf("A c%0d d_done", c), d_done, 1'b0);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk1("A c6 d_done", d_done, 1'b1);
    chk32("A c6 d_rdata", d_rdata, 32'h12345678);
    chk1("A c6 bus_err", bus_err, 1'b0);
    chk1("A c6 d_stall", d_stall, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk1("A c7 d_done", d_done, 1'b0);
    chk32("A c7 d_rdata", d_rdata, 32'h12345678);

    // B: read never answered, aborted 8 cycles after the grant
    tick();
    d_rd = 1'b1; d_addr = 32'h400;
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("B c1 mem_valid", mem_valid, 1'b1);
    for (int c = 2; c <= 7; c++) begin
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      chk1($sformatf("B c%0d d_done", c), d_done, 1'b0);
      chk1($sformatf("B c%0d bus_err", c), bus_err, 1'b0);
    end
    tick();
    @(negedge clk);
    chk1("B c8 bus_err", bus_err, 1'b1);
    chk1("B c8 d_done", d_done, 1'b1);
    chk1("B c8 if_done", if_done, 1'b0);
    chk32("B c8 d_rdata", d_rdata, 32'hDEADBEEF);
    tick();
    idle_inputs();
    @(negedge clk);
    chk1("B c9 bus_err", bus_err, 1'b0);
    chk1("B c9 d_done", d_done, 1'b0);
    chk32("B c9 d_rdata", d_rdata, 32'hDEADBEEF);
    fetch_zw(32'h44, 32'h0000_0013, "B2");

    // C: rvalid with the REQ->RESP step is ignored; completion on the expiry cycle wins
    tick();
    d_rd = 1'b1; d_addr = 32'h500;
    tick();
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = J;
    @(negedge clk);
    chk1("C c1 d_done", d_done, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      tick();
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      chk1($sformatf("C c%0d d_done", c), d_done, 1'b0);
    end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0008;
    @(negedge clk);
    chk1("C c8 d_done", d_done, 1'b1);
    chk1("C c8 bus_err", bus_err, 1'b0);
    chk32("C c8 d_rdata", d_rdata, 32'hCAFE0008);
    tick();
    idle_inputs();
    @(negedge clk);
    chk1("C c9 d_done", d_done, 1'b0);
    chk1("C c9 mem_valid", mem_valid, 1'b0);

    // D: reset while in RESP, stale rvalid afterwards
    tick();
    if_req = 1'b1; if_addr = 32'h60;
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk1("D c1 mem_valid", mem_valid, 1'b1);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk1("D c2 if_done", if_done, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    if_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h99999999;
    @(negedge clk);
    chk1("D c4 if_done", if_done, 1'b0);
    chk1("D c4 d_done", d_done, 1'b0);
    chk1("D c4 mem_valid", mem_valid, 1'b0);
    chk32("D c4 mem_addr", mem_addr, 32'h0);
    chk32("D c4 if_rdata", if_rdata, 32'h0);
    chk32("D c4 d_rdata", d_rdata, 32'h0);
    chk1("D c4 bus_err", bus_err, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk1("D c5 mem_valid", mem_valid, 1'b0);
    chk1("D c5 if_done", if_done, 1'b0);
    fetch_zw(32'h80, 32'h0000_0093, "D2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-ported unified memory between the pipelined CPU's instruction-fetch port and its data (load/store) port.
- Arbitrates the two ports, sequences each memory transaction through a small FSM, and returns per-port done pulses and stall signals.
- Sits between the CPU core and the memory model or SRAM controller.
- Enforces fetch anti-starvation and a memory-response timeout.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced
TIMEOUT_CYC, 64, cycles in REQ+RESP before abort; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
if_req  in  1  fetch request; held until if_done
if_addr  in  32  fetch byte address (word aligned)
if_rdata  out  32  fetch data, valid when if_done
if_done  out  1  one-cycle completion pulse for fetch
if_stall  out  1  if_req & ~if_done
d_rd  in  1  load request; held until d_done
d_wr  in  1  store request; held until d_done
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_wstrb  in  4  store byte enables
d_rdata  out  32  load data, valid when d_done
d_done  out  1  one-cycle completion pulse for data
d_stall  out  1  (d_rd|d_wr) & ~d_done
mem_valid  out  1  request to memory
mem_we  out  1  1 = write
mem_addr  out  32  latched address
mem_wdata  out  32  latched write data
mem_wstrb  out  4  latched strobes; 4'b0000 on reads
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, owner=NONE, streak=0, timer=0.
  - mem_valid=0, mem_we=0, mem_addr/wdata=0, mem_wstrb=0, bus_err=0.
  - if_done=d_done=0, rdata outputs=0.
- Reset mid-transaction: FSM abandons and returns to IDLE; mem_valid drops the next cycle. A mem_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE arbitration (only place a grant happens):
  - Data pending and (fetch idle or streak<STARVE_LIMIT) → grant DATA.
  - Otherwise, fetch pending → grant FETCH.
  - Granting latches owner, addr, wdata, wstrb and we into registers; next state REQ.
- Streak counter:
  - Increments on a DATA grant while if_req=1.
  - Clears on a FETCH grant, or on a DATA grant with if_req=0.
  - Saturates at STARVE_LIMIT.
- d_rd and d_wr both high: treated as a write.
- REQ: mem_valid=1 with the latched fields.
  - mem_ready=1 and write → owner's done pulses this cycle, state IDLE.
  - mem_ready=1 and read → RESP.
- RESP: mem_valid=0.
  - mem_rvalid=1 → owner's done=1 and owner's rdata=mem_rdata (combinational pass-through), state IDLE.
  - mem_rvalid in the same cycle as the REQ→RESP transition is not sampled; it counts only when state==RESP.
- Latency:
  - Zero-wait memory (mem_ready and mem_rvalid asserted immediately): request seen in cycle 0, mem_valid in cycle 1, done in cycle 2 for reads and cycle 1 for writes.
  - Back-to-back: the next grant is made in the IDLE cycle after done, so there is a minimum 1-cycle gap between transactions.
- Timeout:
  - timer counts every cycle in REQ/RESP and clears on entering IDLE.
  - When timer reaches TIMEOUT_CYC-1 without completion: owner's done=1, rdata=ERR_DATA, bus_err=1, state IDLE.
  - Completion in the same cycle as expiry takes precedence; no bus_err.
- Non-owner outputs: done=0 and rdata holds its last value.
- Requester contract: signals stay stable while stalled. Dropping a request mid-transaction does not abort it; the done pulse still fires.

Decomposition:
- Shared package rv_mem_pkg holds:
  - state enum {IDLE, REQ, RESP};
  - owner enum {NONE, FETCH, DATA};
  - ERR_DATA default constant.
- Sub-module rv_mem_timeout: a loadable cycle counter with clear/enable and an expire output, parameterised by TIMEOUT_CYC. It is reused later for the peripheral bus.

Test Plan:
1. Zero-wait memory, if_req=1, if_addr=0x0000_0010, mem_rdata=0x0010_0313 → mem_valid at cycle 1 with mem_addr=0x10, if_done at cycle 2 with if_rdata=0x0010_0313, if_stall high for cycles 0–1.
2. Simultaneous if_req and d_wr (addr 0x100, wdata 0x5, wstrb 4'b0001) → data granted first: mem_we=1, mem_wstrb=0001; fetch granted in the next IDLE; if_done follows d_done.
3. d_rd continuously re-asserted with if_req held, STARVE_LIMIT=4 → exactly 4 data grants, then 1 fetch grant, streak back to 0.
4. mem_ready delayed 3 cycles, mem_rvalid delayed 5 cycles → mem_valid/mem_addr stable throughout REQ, done exactly one cycle, no bus_err.
5. TIMEOUT_CYC=8, mem_rvalid never asserted → bus_err and d_done at cycle 8 after grant, d_rdata=0xDEADBEEF; the next request is served normally.
6. reset=0 asserted while in RESP, late mem_rvalid after release → FSM stays in IDLE, no done, outputs at reset values.
